// File: rtl/trng_pkg.sv
// Shared sizing helpers for the TRNG post-processor.
// Latency: none (constants and pure functions only).
// Backpressure: n/a.
package trng_pkg;

  // Accumulator capacity: two output words, so a full word can wait while another fills.
  function automatic int acc_cap(input int word_w);
    return 2 * word_w;
  endfunction

  // Width of the accumulator fill level (0..ACC_CAP inclusive).
  function automatic int fill_w(input int word_w);
    return $clog2(2 * word_w + 1);
  endfunction

  // Width of a repetition counter able to hold REP_LIMIT.
  function automatic int rep_w(input int rep_limit);
    return $clog2(rep_limit + 1);
  endfunction

  // Number of set bits, used as the size of one cycle's batch of extracted bits.
  function automatic logic [3:0] popcount(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) begin
      n = n + 4'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/trng_vn_channel.sv
// One entropy channel: 2-FF synchroniser, von Neumann pair extractor, repetition-count health test.
// Latency: emit_bit/emit_vld registered, valid 1 cycle after the sampling edge; sync adds 2 cycles before that.
// Backpressure: none; the parent decides whether an emitted bit is kept or dropped.
// Ports: i_clk/i_rst_n clock and async active-low reset; en clears state when low; smp sample event;
//        raw async entropy bit; emit_bit/emit_vld extracted bit; rep_hit repetition limit reached.
module trng_vn_channel #(
  parameter int REP_LIMIT = 16,
  parameter int REP_W     = 5
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic en,
  input  logic smp,
  input  logic raw,
  output logic emit_bit,
  output logic emit_vld,
  output logic rep_hit
);

  logic             sync_1, sync_2;
  logic             phase;
  logic             first_smp;
  logic             last_smp;
  logic [REP_W-1:0] rep_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
    end else begin
      sync_1 <= raw;
      sync_2 <= sync_1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      phase     <= 1'b0;
      first_smp <= 1'b0;
      last_smp  <= 1'b0;
      rep_cnt   <= '0;
      emit_bit  <= 1'b0;
      emit_vld  <= 1'b0;
    end else if (!en) begin
      phase    <= 1'b0;
      rep_cnt  <= '0;
      emit_vld <= 1'b0;
    end else begin
      emit_vld <= 1'b0;
      if (smp) begin
        if (!phase) begin
          first_smp <= sync_2;
          phase     <= 1'b1;
        end else begin
          phase <= 1'b0;
          // 10 emits 1 and 01 emits 0: the emitted bit is the first sample of the pair.
          if (first_smp != sync_2) begin
            emit_vld <= 1'b1;
            emit_bit <= first_smp;
          end
        end
        // A zero count means no sample seen since clear; the first sample starts a run of 1.
        if (rep_cnt == '0 || sync_2 != last_smp) begin
          rep_cnt <= REP_W'(1);
        end else if (rep_cnt != REP_W'(REP_LIMIT)) begin
          rep_cnt <= rep_cnt + REP_W'(1);
        end
        last_smp <= sync_2;
      end
    end
  end

  assign rep_hit = (rep_cnt == REP_W'(REP_LIMIT));

endmodule

// File: rtl/trng_postproc.sv
// Multi-channel TRNG post-processor: per-channel von Neumann extraction, bit packing into words.
// Latency: strobe completing a word -> o_valid after 2 cycles.
// Backpressure: valid/ready; word held while stalled, whole batches dropped when the 2-word accumulator would overflow.
// Ports: i_clk, i_rst_n; i_en (low clears datapath); i_sample_stb; i_raw[NUM_CH]; o_word/o_valid/i_ready;
//        o_health_fail sticky repetition failure; o_drop_cnt saturating count of dropped batches.
module trng_postproc
  import trng_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int WORD_W    = 8,
  parameter int REP_LIMIT = 16,
  parameter int DROP_W    = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_en,
  input  logic              i_sample_stb,
  input  logic [NUM_CH-1:0] i_raw,
  output logic [WORD_W-1:0] o_word,
  output logic              o_valid,
  input  logic              i_ready,
  output logic              o_health_fail,
  output logic [DROP_W-1:0] o_drop_cnt
);

  localparam int ACC_CAP = acc_cap(WORD_W);
  localparam int FILL_W  = fill_w(WORD_W);
  localparam int REP_W   = rep_w(REP_LIMIT);
  localparam int SUM_W   = FILL_W + 1;

  logic                smp;
  logic [NUM_CH-1:0]   emit_bit, emit_vld, rep_hit;
  logic [ACC_CAP-1:0]  batch_ext;
  logic [3:0]          batch_k;
  logic [ACC_CAP-1:0]  acc;
  logic [FILL_W-1:0]   fill;
  logic [SUM_W-1:0]    sum;
  logic                drop;
  logic [FILL_W-1:0]   fill_eff;
  logic [ACC_CAP-1:0]  merged;
  logic                reg_free;
  logic                do_load;
  logic                active;

  assign smp = i_sample_stb & i_en & ~o_health_fail;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    trng_vn_channel #(
      .REP_LIMIT (REP_LIMIT),
      .REP_W     (REP_W)
    ) u_ch (
      .i_clk    (i_clk),
      .i_rst_n  (i_rst_n),
      .en       (i_en),
      .smp      (smp),
      .raw      (i_raw[g]),
      .emit_bit (emit_bit[g]),
      .emit_vld (emit_vld[g]),
      .rep_hit  (rep_hit[g])
    );
  end

  // Compact the valid bits, lowest channel ending at bit 0: walk channels high to low, shifting in.
  always_comb begin
    batch_ext = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (emit_vld[i]) begin
        batch_ext = {batch_ext[ACC_CAP-2:0], emit_bit[i]};
      end
    end
  end

  assign batch_k  = popcount(8'(emit_vld));
  assign sum      = {1'b0, fill} + SUM_W'(batch_k);
  // Normal datapath operation: enabled, not failed and not failing on this edge.
  assign active   = i_en & ~o_health_fail & ~(|rep_hit);
  assign drop     = sum > SUM_W'(ACC_CAP);
  assign fill_eff = drop ? fill : sum[FILL_W-1:0];
  assign merged   = drop ? acc : (acc | (batch_ext << fill));
  assign reg_free = ~o_valid | i_ready;
  // A stalled full word may load as soon as the register frees, even on a cycle with no new batch.
  assign do_load  = reg_free & (fill_eff >= FILL_W'(WORD_W));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      acc           <= '0;
      fill          <= '0;
      o_word        <= '0;
      o_valid       <= 1'b0;
      o_health_fail <= 1'b0;
      o_drop_cnt    <= '0;
    end else begin
      if (active && drop && o_drop_cnt != '1) begin
        o_drop_cnt <= o_drop_cnt + DROP_W'(1);
      end

      if (!i_en) begin
        acc           <= '0;
        fill          <= '0;
        o_valid       <= 1'b0;
        o_health_fail <= 1'b0;
      end else if (!o_health_fail) begin
        if (|rep_hit) begin
          // Failure takes priority over any load or append on this edge.
          o_health_fail <= 1'b1;
          o_valid       <= 1'b0;
          acc           <= '0;
          fill          <= '0;
        end else if (do_load) begin
          o_word  <= merged[WORD_W-1:0];
          o_valid <= 1'b1;
          acc     <= merged >> WORD_W;
          fill    <= fill_eff - FILL_W'(WORD_W);
        end else begin
          acc  <= merged;
          fill <= fill_eff;
          if (i_ready) begin
            o_valid <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_trng_postproc.sv
// Randomised and directed bench for trng_postproc with a queue-based reference model and scoreboard.
// Latency: n/a.
// Backpressure: consumer ready driven directly or randomly with a chosen acceptance rate.
module tb_trng_postproc;

  localparam int NUM_CH    = 4;
  localparam int WORD_W    = 8;
  localparam int REP_LIMIT = 16;
  localparam int DROP_W    = 8;
  localparam int CAP       = 2 * WORD_W;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              en = 1'b0;
  logic              stb = 1'b0;
  logic              ready = 1'b0;
  logic [NUM_CH-1:0] raw = '0;
  logic [WORD_W-1:0] word;
  logic              valid;
  logic              hfail;
  logic [DROP_W-1:0] drop;

  always #5 clk = ~clk;

  trng_postproc #(
    .NUM_CH    (NUM_CH),
    .WORD_W    (WORD_W),
    .REP_LIMIT (REP_LIMIT),
    .DROP_W    (DROP_W)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_en          (en),
    .i_sample_stb  (stb),
    .i_raw         (raw),
    .o_word        (word),
    .o_valid       (valid),
    .i_ready       (ready),
    .o_health_fail (hfail),
    .o_drop_cnt    (drop)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit               m_valid, m_fail;
  int               m_drop;
  bit               acc_q[$];
  bit               pend[$];
  logic [WORD_W-1:0] exp_q[$];
  bit               ph[NUM_CH];
  bit               first_s[NUM_CH];
  bit               last_s[NUM_CH];
  int               run[NUM_CH];
  bit               m_hit, m_free, m_ev, s_bit;
  logic [WORD_W-1:0] m_w;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid = 0; m_fail = 0; m_drop = 0;
      acc_q.delete(); pend.delete(); exp_q.delete();
      for (int c = 0; c < NUM_CH; c++) begin
        ph[c] = 0; first_s[c] = 0; last_s[c] = 0; run[c] = 0;
      end
    end else begin
      m_ev  = stb && en && !m_fail;
      m_hit = 0;
      for (int c = 0; c < NUM_CH; c++) if (run[c] == REP_LIMIT) m_hit = 1;
      if (!en) begin
        if (m_valid && !ready) void'(exp_q.pop_back());
        m_valid = 0; m_fail = 0; acc_q.delete();
        for (int c = 0; c < NUM_CH; c++) begin ph[c] = 0; run[c] = 0; end
      end else if (!m_fail) begin
        if (m_hit) begin
          if (m_valid && !ready) void'(exp_q.pop_back());
          m_valid = 0; m_fail = 1; acc_q.delete();
        end else begin
          m_free = !m_valid || ready;
          if (acc_q.size() + pend.size() > CAP) begin
            if (m_drop < 255) m_drop++;
          end else begin
            foreach (pend[i]) acc_q.push_back(pend[i]);
          end
          if (m_free && acc_q.size() >= WORD_W) begin
            m_w = '0;
            for (int b = 0; b < WORD_W; b++) m_w[b] = acc_q.pop_front();
            exp_q.push_back(m_w);
            m_valid = 1;
          end else if (ready) begin
            m_valid = 0;
          end
        end
      end
      pend.delete();
      if (m_ev) begin
        for (int c = 0; c < NUM_CH; c++) begin
          s_bit = raw[c];
          if (run[c] == 0 || s_bit != last_s[c]) run[c] = 1;
          else if (run[c] < REP_LIMIT) run[c]++;
          last_s[c] = s_bit;
          if (!ph[c]) begin
            first_s[c] = s_bit; ph[c] = 1;
          end else begin
            ph[c] = 0;
            if (first_s[c] != s_bit) pend.push_back(first_s[c]);
          end
        end
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  logic [WORD_W-1:0] last_word = '0;
  int                words_seen = 0;
  logic [WORD_W-1:0] exp_w;

  always @(negedge clk) begin
    if (rst_n) begin
      chk("valid", 32'(valid), 32'(m_valid));
      chk("health_fail", 32'(hfail), 32'(m_fail));
      chk("drop_cnt", 32'(drop), 32'(m_drop));
      if (valid && ready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL word: unexpected word %0h with no expected word queued", word);
        end else begin
          exp_w = exp_q.pop_front();
          chk("word", 32'(word), 32'(exp_w));
        end
        last_word = word;
        words_seen++;
      end
    end
  end

  // ---------------- stimulus ----------------
  int rdy_pct = -1;

  task automatic tick();
    @(posedge clk);
    #1;
    if (rdy_pct >= 0) ready = ($urandom_range(0, 99) < rdy_pct);
  endtask

  // Raw held 4 cycles ahead of the strobe so the synchronised value is settled.
  task automatic strobe(input logic [NUM_CH-1:0] v);
    raw = v;
    repeat (4) tick();
    stb = 1'b1;
    tick();
    stb = 1'b0;
  endtask

  task automatic pair(input logic [NUM_CH-1:0] f, input logic [NUM_CH-1:0] s);
    strobe(f);
    strobe(s);
  endtask

  task automatic en_pulse();
    en = 1'b0;
    tick();
    en = 1'b1;
  endtask

  int          ws;
  logic [NUM_CH-1:0] f0s [9];
  logic [NUM_CH-1:0] s0s [9];
  bit          o;

  initial begin
    repeat (3) tick();
    chk("reset_word", 32'(word), 0);
    chk("reset_valid", 32'(valid), 0);
    chk("reset_fail", 32'(hfail), 0);
    chk("reset_drop", 32'(drop), 0);
    rst_n = 1'b1; en = 1'b1; ready = 1'b1;
    tick();

    // Channel 0 pairs 10x4, 11, 01x4; other channels send equal pairs (no output, short runs).
    for (int j = 0; j < 9; j++) begin
      f0s[j] = (j < 5) ? 4'b0001 : 4'b0000;
      s0s[j] = (j < 4) ? 4'b0000 : 4'b0001;
    end
    for (int j = 0; j < 9; j++) begin
      o = j[0];
      pair({{3{o}}, f0s[j][0]}, {{3{o}}, s0s[j][0]});
    end
    @(negedge clk); chk("lat_c1_valid", 32'(valid), 0);
    tick(); @(negedge clk);
    chk("lat_c2_valid", 32'(valid), 1);
    chk("lat_c2_word", 32'(word), 32'h0F);
    tick(); @(negedge clk); chk("lat_c3_valid", 32'(valid), 0);

    // All channels 10 then all 01.
    pair(4'hF, 4'h0);
    pair(4'h0, 4'hF);
    repeat (3) tick();
    chk("batch_word", 32'(last_word), 32'h0F);
    chk("batch_drop", 32'(drop), 0);

    // Stalled consumer: one word held, accumulator fills to 16, remaining batches dropped.
    ready = 1'b0;
    for (int j = 0; j < 13; j++) pair(4'hF, 4'h0);
    tick();
    chk("stall_valid", 32'(valid), 1);
    chk("stall_word", 32'(word), 32'hFF);
    chk("stall_drop", 32'(drop), 7);
    ws = words_seen;
    ready = 1'b1;
    repeat (6) tick();
    chk("drain_count", 32'(words_seen - ws), 3);
    chk("drain_word", 32'(last_word), 32'hFF);

    // Channel 2 held at 1 for REP_LIMIT samples.
    en_pulse();
    for (int n = 0; n < REP_LIMIT; n++) begin
      o = n[1];
      strobe({o, 1'b1, o, o});
    end
    @(negedge clk); chk("hf_before", 32'(hfail), 0);
    tick(); @(negedge clk);
    chk("hf_set", 32'(hfail), 1);
    chk("hf_valid", 32'(valid), 0);
    ws = words_seen;
    pair(4'hF, 4'h0);
    pair(4'h0, 4'hF);
    repeat (3) tick();
    chk("hf_no_words", 32'(words_seen - ws), 0);
    chk("hf_sticky", 32'(hfail), 1);
    en_pulse();
    @(negedge clk); chk("hf_cleared", 32'(hfail), 0);

    // Five stale bits, enable pulse, then 8'hA5.
    pair(4'hF, 4'h0);
    pair(4'hF, 4'hE);
    tick();
    en_pulse();
    ws = words_seen;
    pair(4'b0101, 4'b1010);
    pair(4'b1010, 4'b0101);
    repeat (3) tick();
    chk("clear_count", 32'(words_seen - ws), 1);
    chk("clear_word", 32'(last_word), 32'hA5);

    // Random data with a mostly-ready then mostly-stalled consumer.
    for (int j = 0; j < 240; j++) begin
      rdy_pct = (j < 160) ? 60 : 8;
      if (j % 40 == 39) en_pulse();
      pair(NUM_CH'($urandom), NUM_CH'($urandom));
    end
    rdy_pct = -1;
    ready = 1'b1;
    repeat (8) tick();

    // Asynchronous reset while a word is presented.
    ready = 1'b0;
    en_pulse();
    pair(4'hF, 4'h0);
    pair(4'h0, 4'hF);
    repeat (2) tick();
    chk("prerst_valid", 32'(valid), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_valid", 32'(valid), 0);
    chk("rst_word", 32'(word), 0);
    chk("rst_drop", 32'(drop), 0);
    tick();
    rst_n = 1'b1;
    ready = 1'b1;
    ws = words_seen;
    repeat (6) tick();
    chk("rst_no_word", 32'(words_seen - ws), 0);
    pair(4'hF, 4'h0);
    pair(4'hF, 4'h0);
    repeat (3) tick();
    chk("rst_fresh_word", 32'(last_word), 32'hFF);

    repeat (10) tick();
    chk("queue_empty", 32'(exp_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
